tx: RTL and testbench



---
 rtl/iso14443a_pkg.sv | 23 ++
 rtl/manchester_encoder.sv | 47 ++++
 rtl/tx.sv | 174 +++++++++++++++++
 tb/tb_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iso14443a_pkg.sv
// Shared types and ISO/IEC 14443A 106 kbit/s timing constants.
// Provides tx_state_t, bit/half-bit/subcarrier lengths and a bit-count helper.
`timescale 1ns/1ps
package iso14443a_pkg;

    localparam int BIT_CYCLES        = 128;
    localparam int HALF_BIT_CYCLES   = 64;
    localparam int SUBCARRIER_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOC,
        ST_DATA,
        ST_PARITY,
        ST_EOC
    } tx_state_t;

    // A data_bits value of 0 stands for a complete 8-bit byte.
    function automatic logic [3:0] bit_count(input logic [2:0] bits);
        return (bits == 3'd0) ? 4'd8 : {1'b0, bits};
    endfunction

endpackage

// File: rtl/manchester_encoder.sv
// Manchester coder for the PICC load modulation output.
// Ports: clk, rst (sync, active-high), i_active (bit being sent), i_bit (bit
// value), i_t (bit timer), o_lm (registered load-modulation drive).
// Build option ISO14443A_TX_SUBCARRIER_EN: gate the envelope with the fc/16
// subcarrier; otherwise emit the envelope only.
`timescale 1ns/1ps
module manchester_encoder
    import iso14443a_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_active,
    input  logic       i_bit,
    input  logic [6:0] i_t,
    output logic       o_lm
);

    localparam int HALF_IDX = $clog2(HALF_BIT_CYCLES);

    logic w_half;
    logic w_mod;
    logic w_lm;
    logic w_unused_t;

    assign w_half = i_t[HALF_IDX];

    // Logic 1 modulates the first half, logic 0 the second half.
    assign w_mod = i_active & (i_bit ^ w_half);

`ifdef ISO14443A_TX_SUBCARRIER_EN
    localparam int SC_IDX = $clog2(SUBCARRIER_CYCLES) - 1;
    assign w_lm = w_mod & ~i_t[SC_IDX];
`else
    assign w_lm = w_mod;
`endif

    assign w_unused_t = ^i_t;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_lm <= 1'b0;
        end else begin
            o_lm <= w_lm;
        end
    end

endmodule

// File: rtl/tx.sv
// ISO/IEC 14443A PICC-to-PCD frame transmitter (SOC, LSB-first data, odd
// parity per full byte, EOC), Manchester coded onto lm_out.
// Ports: clk, rst (sync, active-high), data/data_bits/last_byte/data_valid
// byte stream in, data_ready accept pulse, busy frame flag, underrun pulse,
// lm_out load-modulation drive. Build option ISO14443A_TX_SUBCARRIER_EN.
`timescale 1ns/1ps
module tx
    import iso14443a_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic [2:0] data_bits,
    input  logic       last_byte,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       busy,
    output logic       underrun,
    output logic       lm_out
);

    tx_state_t  r_state, w_state_nx;
    logic [6:0] r_t, w_t_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic [3:0] r_left, w_left_nx;
    logic       r_full, w_full_nx;
    logic       r_last, w_last_nx;
    logic       r_par, w_par_nx;

    logic w_wrap;
    logic w_end_byte;
    logic w_take;
    logic w_ready;
    logic w_underrun;
    logic w_bit_nx;
    logic w_active_nx;

    assign w_wrap = (r_t == 7'(BIT_CYCLES - 1));

    always_comb begin
        w_state_nx = r_state;
        w_t_nx     = (r_state == ST_IDLE) ? 7'd0 : r_t + 7'd1;
        w_shift_nx = r_shift;
        w_left_nx  = r_left;
        w_full_nx  = r_full;
        w_last_nx  = r_last;
        w_par_nx   = r_par;
        w_end_byte = 1'b0;
        w_take     = 1'b0;
        w_ready    = 1'b0;
        w_underrun = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (data_valid) begin
                    w_take     = 1'b1;
                    w_state_nx = ST_SOC;
                end
            end
            ST_SOC: begin
                if (w_wrap) begin
                    w_state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_wrap) begin
                    w_par_nx   = r_par ^ r_shift[0];
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_left_nx  = r_left - 4'd1;
                    if (r_left == 4'd1) begin
                        if (r_full) begin
                            w_state_nx = ST_PARITY;
                        end else begin
                            w_end_byte = 1'b1;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (w_wrap) begin
                    w_end_byte = 1'b1;
                end
            end
            ST_EOC: begin
                if (w_wrap) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_end_byte) begin
            if (r_last) begin
                w_state_nx = ST_EOC;
            end else if (data_valid) begin
                w_take     = 1'b1;
                w_state_nx = ST_DATA;
            end else begin
                w_underrun = 1'b1;
                w_state_nx = ST_EOC;
            end
        end

        if (w_take) begin
            w_shift_nx = data;
            w_left_nx  = bit_count(data_bits);
            w_full_nx  = (data_bits == 3'd0);
            w_last_nx  = last_byte;
            w_par_nx   = 1'b1;
            w_ready    = 1'b1;
        end
    end

    // The encoder registers its output, so it is fed the values that
    // the bit and timer will hold in the coming cycle.
    always_comb begin
        w_bit_nx    = 1'b0;
        w_active_nx = 1'b0;
        unique case (w_state_nx)
            ST_SOC: begin
                w_bit_nx    = 1'b1;
                w_active_nx = 1'b1;
            end
            ST_DATA: begin
                w_bit_nx    = w_shift_nx[0];
                w_active_nx = 1'b1;
            end
            ST_PARITY: begin
                w_bit_nx    = w_par_nx;
                w_active_nx = 1'b1;
            end
            default: begin
                w_bit_nx    = 1'b0;
                w_active_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= 7'd0;
            r_shift <= 8'd0;
            r_left  <= 4'd0;
            r_full  <= 1'b0;
            r_last  <= 1'b0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_t     <= w_t_nx;
            r_shift <= w_shift_nx;
            r_left  <= w_left_nx;
            r_full  <= w_full_nx;
            r_last  <= w_last_nx;
            r_par   <= w_par_nx;
        end
    end

    manchester_encoder u_enc (
        .clk      (clk),
        .rst      (rst),
        .i_active (w_active_nx),
        .i_bit    (w_bit_nx),
        .i_t      (w_t_nx),
        .o_lm     (lm_out)
    );

    assign data_ready = w_ready & ~rst;
    assign underrun   = w_underrun & ~rst;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tx.sv
// Testbench for tx: frame table, hand sequences and random frames checked
// against a bit-list/waveform reference model.
`timescale 1ns/1ps
module tb_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [2:0] data_bits;
    logic       last_byte;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       underrun;
    logic       lm_out;

    always #5 clk = ~clk;

    tx dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_bits  (data_bits),
        .last_byte  (last_byte),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .underrun   (underrun),
        .lm_out     (lm_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int              n;
        logic [3:0][7:0] d;
        logic [3:0][2:0] b;
        logic [3:0]      l;
        int              busy_cyc;
        int              rdy;
        int              und;
    } vec_t;

    vec_t vt[5];

    logic [7:0] f_d[4];
    logic [2:0] f_b[4];
    logic       f_l[4];
    int         f_present;

    bit   exp_lm[$];
    int   exp_rdy[$];
    int   exp_und;
    logic soc_lm[64];

    task automatic load_vec(input int v);
        for (int i = 0; i < 4; i++) begin
            f_d[i] = vt[v].d[i];
            f_b[i] = vt[v].b[i];
            f_l[i] = vt[v].l[i];
        end
        f_present = vt[v].n;
    endtask

    // Reference: list the on-air bits, then expand each into 128 samples.
    task automatic build_model();
        bit bits[$];
        int t;
        int nb;
        bit p;
        bit m;
        exp_lm.delete();
        exp_rdy.delete();
        bits.push_back(1'b1);
        exp_rdy.push_back(0);
        t = 128;
        for (int i = 0; i < f_present; i++) begin
            nb = (f_b[i] == 3'd0) ? 8 : int'(f_b[i]);
            p  = 1'b1;
            for (int j = 0; j < nb; j++) begin
                bits.push_back(f_d[i][j]);
                p = p ^ f_d[i][j];
            end
            if (f_b[i] == 3'd0) begin
                bits.push_back(p);
                nb = nb + 1;
            end
            t = t + nb * 128;
            if (i + 1 < f_present) exp_rdy.push_back(t);
        end
        exp_und = f_l[f_present-1] ? -1 : t;
        foreach (bits[k]) begin
            for (int c = 0; c < 128; c++) begin
                m = bits[k] ? (c < 64) : (c >= 64);
`ifdef ISO14443A_TX_SUBCARRIER_EN
                m = m & ((c % 16) < 8);
`endif
                exp_lm.push_back(m);
            end
        end
        for (int c = 0; c < 128; c++) exp_lm.push_back(1'b0);
    endtask

    task automatic present(input int i);
        data       = f_d[i];
        data_bits  = f_b[i];
        last_byte  = f_l[i];
        data_valid = 1'b1;
    endtask

    task automatic run_frame(input string tag, output int busy_len,
                             output int rdy_cnt, output int und_cnt);
        int idx;
        int k;
        int wave_err;
        int first_err;
        int und_t;
        int len;
        bit eb;
        bit el;
        int rdy_t[$];
        build_model();
        len       = exp_lm.size();
        busy_len  = 0;
        und_cnt   = 0;
        und_t     = -1;
        wave_err  = 0;
        first_err = -1;
        @(negedge clk);
        present(0);
        #1;
        k = 0;
        while (data_ready !== 1'b1 && k < 4) begin
            @(negedge clk);
            #1;
            k++;
        end
        check($sformatf("%s_accept", tag), data_ready, 1);
        rdy_cnt = 0;
        if (data_ready !== 1'b1) begin
            data_valid = 1'b0;
            return;
        end
        rdy_t.push_back(0);
        idx = 1;
        for (int c = 1; c <= len + 3; c++) begin
            @(negedge clk);
            eb = (c <= len);
            el = eb ? exp_lm[c-1] : 1'b0;
            if (busy === 1'b1) busy_len++;
            if (busy !== eb || lm_out !== el) begin
                wave_err++;
                if (first_err < 0) first_err = c;
            end
            if (c <= 64) soc_lm[c-1] = lm_out;
            if (idx < f_present) present(idx);
            else data_valid = 1'b0;
            #1;
            if (data_ready === 1'b1) begin
                rdy_t.push_back(c);
                idx++;
            end
            if (underrun === 1'b1) begin
                und_cnt++;
                und_t = c;
            end
        end
        data_valid = 1'b0;
        rdy_cnt = rdy_t.size();
        check($sformatf("%s_wave_errs_from_cycle_%0d", tag, first_err),
              wave_err, 0);
        check($sformatf("%s_busy_len", tag), busy_len, len);
        check($sformatf("%s_ready_cnt", tag), rdy_cnt, exp_rdy.size());
        for (int i = 1; i < exp_rdy.size() && i < rdy_t.size(); i++)
            check($sformatf("%s_ready%0d_cycle", tag, i), rdy_t[i], exp_rdy[i]);
        check($sformatf("%s_underrun_cnt", tag), und_cnt, (exp_und < 0) ? 0 : 1);
        if (exp_und >= 0)
            check($sformatf("%s_underrun_cycle", tag), und_t, exp_und);
    endtask

    initial begin
        int bl;
        int rc;
        int uc;
        int ones;
        int edges;
        int n;

        vt[0] = '{1, 32'h0000_0000, 12'h000, 4'b0001, 1408, 1, 0};
        vt[1] = '{1, 32'h0000_000A, 12'h004, 4'b0001,  768, 1, 0};
        vt[2] = '{2, 32'h0000_0044, 12'h000, 4'b0010, 2560, 2, 0};
        vt[3] = '{1, 32'h0000_0055, 12'h000, 4'b0000, 1408, 1, 1};
        vt[4] = '{2, 32'h0000_8105, 12'h003, 4'b0010, 1792, 2, 0};

        rst        = 1'b1;
        data       = 8'd0;
        data_bits  = 3'd0;
        last_byte  = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_lm", lm_out, 0);
        check("reset_ready", data_ready, 0);
        check("reset_underrun", underrun, 0);

        for (int v = 0; v < 5; v++) begin
            load_vec(v);
            run_frame($sformatf("vec%0d", v), bl, rc, uc);
            check($sformatf("vec%0d_busy_table", v), bl, vt[v].busy_cyc);
            check($sformatf("vec%0d_ready_table", v), rc, vt[v].rdy);
            check($sformatf("vec%0d_underrun_table", v), uc, vt[v].und);
            if (v == 0) begin
                ones  = 0;
                edges = 0;
                for (int k = 0; k < 64; k++) begin
                    if (soc_lm[k] === 1'b1) ones++;
                    if (k > 0 && soc_lm[k] !== soc_lm[k-1]) edges++;
                end
`ifdef ISO14443A_TX_SUBCARRIER_EN
                check("soc_half_ones", ones, 32);
                check("soc_half_edges", edges, 7);
`else
                check("soc_half_ones", ones, 64);
                check("soc_half_edges", edges, 0);
`endif
            end
        end

        // Reset in the middle of a frame.
        @(negedge clk);
        data       = 8'h00;
        data_bits  = 3'd0;
        last_byte  = 1'b1;
        data_valid = 1'b1;
        #1;
        check("midrst_accept", data_ready, 1);
        uc = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            data_valid = 1'b0;
            #1;
            if (underrun === 1'b1) uc++;
        end
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_lm_after", lm_out, 0);
        check("midrst_busy_after", busy, 0);
        #1;
        check("midrst_ready_after", data_ready, 0);
        if (underrun === 1'b1) uc++;
        check("midrst_no_underrun", uc, 0);
        repeat (2) @(negedge clk);
        load_vec(0);
        run_frame("after_rst", bl, rc, uc);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                f_d[i] = 8'($urandom);
                f_b[i] = ($urandom_range(0, 1) == 0) ? 3'd0
                                                    : 3'($urandom_range(1, 7));
                f_l[i] = (i == n - 1);
            end
            if ($urandom_range(0, 3) == 0) f_l[n-1] = 1'b0;
            f_present = n;
            run_frame($sformatf("rnd%0d", r), bl, rc, uc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
